signed_extreme_tracker: RTL and testbench
=========================================

// Module: signed_extreme_tracker
// PURPOSE
//  Streaming signed max/min finder: a framed sequence of WIDTH-bit two's-complement samples
//  comes in; each frame yields its extreme value, the index of that value, the sample count
//  and a signed threshold verdict. Sits after the feature/stage score pipeline in the
//  detector; picks the best-scoring window per scan row and flags it against the
//  detection threshold. Generalises the single-pair signed greater-than compare to a
//  sequential, handshaked, mode-selectable tracker.
// PARAMETERS
//  WIDTH    32   sample/threshold width, two's complement
//  MAX_LEN  256  max samples per frame; frame auto-closes at this count (>=2)
//  MODE     0    0 = track maximum (strict signed >), 1 = track minimum (strict signed <)
//  IDX_W    $clog2(MAX_LEN)  derived localparam, not overridden
// PORTS
//  clock       in   1        single clock, all logic rising-edge
//  reset_n     in   1        asynchronous, active-low reset
//  clear       in   1        sync abort: drop frame and pending result, return to IDLE
//  thresh      in   WIDTH    signed threshold, sampled on first sample of frame
//  in_valid    in   1        sample present
//  in_ready    out  1        tracker accepts sample
//  in_data     in   WIDTH    signed sample
//  in_last     in   1        final sample of frame
//  out_valid   out  1        result held
//  out_ready   in   1        consumer takes result
//  out_value   out  WIDTH    extreme sample of frame (signed)
//  out_index   out  IDX_W    0-based position of extreme; ties keep EARLIEST index
//  out_count   out  IDX_W+1  samples in frame, 1..MAX_LEN
//  out_hit     out  1        MODE0: out_value > thresh; MODE1: out_value < thresh (signed, strict)
// BEHAVIOUR
//  - Reset (reset_n=0, async): state=IDLE; in_ready=0 while reset asserted, 1 from first
//    clock after release; out_valid=0; out_value/out_index/out_count/out_hit=0.
//  - FSM: IDLE -> ACC on accepted non-closing sample; IDLE/ACC -> HOLD on accepted closing
//    sample; HOLD -> IDLE on out_valid&&out_ready. Closing sample = in_last=1 OR sample number
//    MAX_LEN (count reaches MAX_LEN). A one-sample frame goes IDLE -> HOLD directly.
//  - in_ready = (state != HOLD) && !clear. Accept = in_valid && in_ready. No bypass: HOLD
//    blocks input even in the cycle out_ready is high; new frame may start next cycle.
//  - First accepted sample: value<=in_data, index<=0, count<=1, thr_q<=thresh.
//  - Later samples at position p: MODE0 replaces when $signed(in_data) > $signed(value),
//    MODE1 when <; index<=p. Equal values never replace. count<=count+1.
//  - All compares are signed: 32'hFFFF_FFFF (-1) is less than 1; msb-differs cases must not
//    fall back to unsigned ordering.
//  - out_hit computed from final value vs thr_q, registered with the result.
//  - Latency: out_valid=1 on the cycle after closing sample is accepted; outputs stable and
//    out_valid held while out_ready=0. Outputs are only meaningful when out_valid=1.
//  - clear=1: state->IDLE, out_valid->0 next cycle, regardless of in_valid/out_ready; a
//    sample presented with clear is not accepted. clear beats a simultaneous handshake.
//  - Reset mid-frame or mid-HOLD: partial frame and pending result discarded.
//  - in_last when count already MAX_LEN cannot occur (frame closed); extra samples start
//    a new frame after HOLD drains.
// TESTING
//  - MODE0, thresh=0, frame {-1, 1, -9348, 754, last} -> value=754, index=3, count=4, hit=1.
//  - MODE0, thresh=-100, frame {-345, -234, -9348, -345345 last} -> value=-234, index=1, hit=0.
//  - Ties: MODE0 frame {232, 232, 232 last} -> index=0; MODE1 {-345,-345 last} -> index=0.
//  - MODE1, thresh=0, frame {984, 34, 2398, 24 last} -> value=24, index=3, hit=0; hold
//    out_ready=0 5 cycles -> outputs stable, in_ready=0; release -> in_ready=1 next cycle.
//  - MAX_LEN=4, 6 samples no in_last -> first result count=4 after sample 4; samples 5-6
//    form second frame closed by in_last, count=2.
//  - clear mid-frame and reset_n pulse in HOLD -> out_valid=0, next frame result has no
//    contamination from aborted samples (index restarts at 0).

Source files
------------

// File: rtl/signed_extreme_tracker.sv
// signed_extreme_tracker
//   Streaming signed max/min finder. It takes a framed stream of WIDTH-bit
//   two's-complement samples and returns one result per frame: the extreme
//   value, its 0-based position (the earliest position wins a tie), the sample
//   count, and a signed threshold verdict.
//
//   Ports
//     clock      rising-edge clock
//     reset_n    asynchronous, active-low reset
//     clear      synchronous abort; drops the partial frame and any pending result
//     thresh     signed threshold, captured on the first sample of each frame
//     in_valid / in_ready / in_data / in_last    sample handshake
//     out_valid / out_ready                      result handshake
//     out_value  extreme sample of the frame
//     out_index  position of the extreme sample
//     out_count  number of samples in the frame, 1..MAX_LEN
//     out_hit    MODE 0: out_value > thresh; MODE 1: out_value < thresh
//
//   Parameters
//     WIDTH    sample and threshold width
//     MAX_LEN  frame closes automatically at this many samples (>= 2)
//     MODE     0 tracks the maximum, 1 tracks the minimum (strict compare)
module signed_extreme_tracker #(
  parameter int WIDTH   = 32,
  parameter int MAX_LEN = 256,
  parameter int MODE    = 0,
  localparam int IDX_W  = $clog2(MAX_LEN)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               clear,
  input  logic [WIDTH-1:0]   thresh,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_value,
  output logic [IDX_W-1:0]   out_index,
  output logic [IDX_W:0]     out_count,
  output logic               out_hit
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic                      ready_en_q, ready_en_d;
  logic signed [WIDTH-1:0]   value_q, value_d;
  logic signed [WIDTH-1:0]   thr_q, thr_d;
  logic [IDX_W-1:0]          index_q, index_d;
  logic [IDX_W:0]            count_q, count_d;
  logic                      hit_q, hit_d;

  logic signed [WIDTH-1:0]   sample;
  logic signed [WIDTH-1:0]   cand_value;
  logic signed [WIDTH-1:0]   cand_thr;
  logic [IDX_W-1:0]          cand_index;
  logic [IDX_W-1:0]          pos;
  logic [IDX_W:0]            cand_count;
  logic                      first;
  logic                      better;
  logic                      cand_replace;
  logic                      cand_hit;
  logic                      closing;
  logic                      accept;

  assign sample = in_data;

  // ready_en_q keeps in_ready low until the first clock edge after reset is
  // released, so nothing is accepted while the flops are still settling.
  assign in_ready = ready_en_q && (state_q != S_HOLD) && !clear;
  assign accept   = in_valid && in_ready;

  // Candidate state if the current sample is accepted. In IDLE the sample
  // opens a new frame, so the old accumulator contents are ignored.
  always_comb begin
    first = (state_q == S_IDLE);
    pos   = first ? '0 : count_q[IDX_W-1:0];
    cand_count = first ? (IDX_W+1)'(1) : count_q + 1'b1;

    // Strict compare: an equal sample never replaces, so ties keep the
    // earliest index.
    if (MODE == 0) begin
      better = sample > value_q;
    end else begin
      better = sample < value_q;
    end

    cand_replace = first || better;
    cand_value   = cand_replace ? sample : value_q;
    cand_index   = cand_replace ? pos : index_q;
    cand_thr     = first ? $signed(thresh) : thr_q;

    if (MODE == 0) begin
      cand_hit = cand_value > cand_thr;
    end else begin
      cand_hit = cand_value < cand_thr;
    end

    closing = in_last || (cand_count == (IDX_W+1)'(MAX_LEN));
  end

  always_comb begin
    state_d    = state_q;
    ready_en_d = 1'b1;
    value_d    = value_q;
    thr_d      = thr_q;
    index_d    = index_q;
    count_d    = count_q;
    hit_d      = hit_q;

    if (clear) begin
      // Abort has priority over both handshakes.
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_ACC: begin
          if (accept) begin
            value_d = cand_value;
            index_d = cand_index;
            count_d = cand_count;
            thr_d   = cand_thr;
            // The verdict follows the running extreme, so it is already
            // correct for the final value when the frame closes.
            hit_d   = cand_hit;
            state_d = closing ? S_HOLD : S_ACC;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      ready_en_q <= 1'b0;
      value_q    <= '0;
      thr_q      <= '0;
      index_q    <= '0;
      count_q    <= '0;
      hit_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_en_q <= ready_en_d;
      value_q    <= value_d;
      thr_q      <= thr_d;
      index_q    <= index_d;
      count_q    <= count_d;
      hit_q      <= hit_d;
    end
  end

  // The accumulator doubles as the result register while in HOLD.
  assign out_valid = (state_q == S_HOLD);
  assign out_value = value_q;
  assign out_index = index_q;
  assign out_count = count_q;
  assign out_hit   = hit_q;

endmodule

// File: tb/tb_signed_extreme_tracker.sv
// Bench for signed_extreme_tracker. Instance 0 tracks the maximum with
// MAX_LEN=4; instance 1 tracks the minimum with MAX_LEN=8. A frame-level
// model stores each accepted frame and scans it when the frame closes. The
// compare process checks both instances against this model on every falling
// edge. Directed frames also check hand-computed literal results.
module tb_signed_extreme_tracker;

  localparam int MAXL  [2] = '{4, 8};
  localparam int MODES [2] = '{0, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        clr       [2];
  logic        in_valid  [2];
  logic        in_last   [2];
  logic        out_ready [2];
  logic [31:0] in_data   [2];
  logic [31:0] thresh    [2];

  logic [1:0]  in_ready;
  logic [1:0]  out_valid;
  logic [1:0]  out_hit;
  logic [31:0] oval0, oval1;
  logic [1:0]  idx0;
  logic [2:0]  cnt0;
  logic [2:0]  idx1;
  logic [3:0]  cnt1;

  logic signed [31:0] oval [2];
  int                 oidx [2];
  int                 ocnt [2];

  always_comb begin
    oval[0] = oval0;
    oval[1] = oval1;
    oidx[0] = int'(idx0);
    oidx[1] = int'(idx1);
    ocnt[0] = int'(cnt0);
    ocnt[1] = int'(cnt1);
  end

  signed_extreme_tracker #(.WIDTH(32), .MAX_LEN(4), .MODE(0)) u_max (
    .clock(clk), .reset_n(rst_n), .clear(clr[0]), .thresh(thresh[0]),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .in_last(in_last[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_value(oval0), .out_index(idx0), .out_count(cnt0), .out_hit(out_hit[0])
  );

  signed_extreme_tracker #(.WIDTH(32), .MAX_LEN(8), .MODE(1)) u_min (
    .clock(clk), .reset_n(rst_n), .clear(clr[1]), .thresh(thresh[1]),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .in_last(in_last[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_value(oval1), .out_index(idx1), .out_count(cnt1), .out_hit(out_hit[1])
  );

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // ---------------- frame-level model + per-cycle compare ----------------
  bit                 m_en   [2];
  bit                 m_hold [2];
  bit                 m_rdy;
  int                 m_len  [2];
  logic signed [31:0] m_fs   [2][8];
  logic signed [31:0] m_thr  [2];
  logic signed [31:0] e_val  [2];
  int                 e_idx  [2];
  int                 e_cnt  [2];
  bit                 e_hit  [2];

  // Inputs change only just after rising edges, so at a falling edge they
  // hold the values the next rising edge will sample. The model checks the
  // current outputs first and then steps over that coming edge.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_en[k]   = 1'b0;
        m_hold[k] = 1'b0;
        m_len[k]  = 0;
      end
      m_rdy = m_en[k] && !m_hold[k] && !clr[k];
      chk($sformatf("k%0d in_ready", k), in_ready[k], m_rdy);
      chk($sformatf("k%0d out_valid", k), out_valid[k], m_hold[k]);
      if (m_hold[k]) begin
        chk($sformatf("k%0d out_value", k), oval[k], e_val[k]);
        chk($sformatf("k%0d out_index", k), oidx[k], e_idx[k]);
        chk($sformatf("k%0d out_count", k), ocnt[k], e_cnt[k]);
        chk($sformatf("k%0d out_hit", k), out_hit[k], e_hit[k]);
      end
      if (rst_n) begin
        if (clr[k]) begin
          m_len[k]  = 0;
          m_hold[k] = 1'b0;
        end else if (m_hold[k]) begin
          if (out_ready[k]) begin
            $display("k%0d result value=%0d index=%0d count=%0d hit=%0d",
                     k, e_val[k], e_idx[k], e_cnt[k], e_hit[k]);
            m_hold[k] = 1'b0;
          end
        end else if (in_valid[k] && m_rdy) begin
          if (m_len[k] == 0) m_thr[k] = thresh[k];
          m_fs[k][m_len[k]] = in_data[k];
          m_len[k]++;
          if (in_last[k] || m_len[k] == MAXL[k]) begin
            e_val[k] = m_fs[k][0];
            e_idx[k] = 0;
            for (int i = 1; i < m_len[k]; i++) begin
              if (MODES[k] == 0 ? (m_fs[k][i] > e_val[k]) : (m_fs[k][i] < e_val[k])) begin
                e_val[k] = m_fs[k][i];
                e_idx[k] = i;
              end
            end
            e_cnt[k]  = m_len[k];
            e_hit[k]  = (MODES[k] == 0) ? (e_val[k] > m_thr[k]) : (e_val[k] < m_thr[k]);
            m_hold[k] = 1'b1;
            m_len[k]  = 0;
          end
        end
        m_en[k] = 1'b1;
      end
    end
  end

  // ---------------- stimulus helpers (called just after a rising edge) ----
  task automatic drive_sample(input int k, input logic [31:0] d, input bit last);
    bit acc;
    int tries;
    in_valid[k] = 1'b1;
    in_data[k]  = d;
    in_last[k]  = last;
    tries = 0;
    do begin
      @(negedge clk);
      acc = in_ready[k];
      @(posedge clk);
      #1;
      tries++;
    end while (!acc && tries < 50);
    if (!acc) chk($sformatf("k%0d accept timeout", k), 0, 1);
    in_valid[k] = 1'b0;
    in_last[k]  = 1'b0;
  endtask

  task automatic expect_result(input int k, input longint val, input int idx,
                               input int cnt, input bit hit);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!out_valid[k] && n < 50);
    chk($sformatf("k%0d lit valid", k), out_valid[k], 1);
    chk($sformatf("k%0d lit value", k), oval[k], val);
    chk($sformatf("k%0d lit index", k), oidx[k], idx);
    chk($sformatf("k%0d lit count", k), ocnt[k], cnt);
    chk($sformatf("k%0d lit hit", k), out_hit[k], hit);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      clr[k] = 1'b0; in_valid[k] = 1'b0; in_last[k] = 1'b0;
      out_ready[k] = 1'b1; in_data[k] = '0; thresh[k] = '0;
    end

    // Reset values
    @(negedge clk); #1;
    chk("rst out_valid", out_valid[0], 0);
    chk("rst in_ready0", in_ready[0], 0);
    chk("rst in_ready1", in_ready[1], 0);
    chk("rst out_value", oval[0], 0);
    chk("rst out_index", oidx[0], 0);
    chk("rst out_count", ocnt[0], 0);
    chk("rst out_hit", out_hit[0], 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("in_ready before first edge", in_ready[0], 0);
    @(posedge clk); #1;
    @(negedge clk); #1;
    chk("in_ready after first edge", in_ready[0], 1);
    @(posedge clk); #1;

    // MODE0, thresh 0: max is 754 at index 3
    thresh[0] = 32'd0;
    drive_sample(0, -32'sd1, 0);
    drive_sample(0, 32'sd1, 0);
    drive_sample(0, -32'sd9348, 0);
    drive_sample(0, 32'sd754, 1);
    expect_result(0, 754, 3, 4, 1);

    // MODE0, thresh -100: all negative, max -234 at index 1, below threshold
    thresh[0] = -32'sd100;
    drive_sample(0, -32'sd345, 0);
    drive_sample(0, -32'sd234, 0);
    drive_sample(0, -32'sd9348, 0);
    drive_sample(0, -32'sd345345, 1);
    expect_result(0, -234, 1, 4, 0);

    // Ties keep the earliest index
    thresh[0] = 32'd0;
    drive_sample(0, 32'sd232, 0);
    drive_sample(0, 32'sd232, 0);
    drive_sample(0, 32'sd232, 1);
    expect_result(0, 232, 0, 3, 1);

    thresh[1] = 32'd0;
    drive_sample(1, -32'sd345, 0);
    drive_sample(1, -32'sd345, 1);
    expect_result(1, -345, 0, 2, 1);

    // MODE1: all-ones is -1, which must be treated as smaller than 1
    drive_sample(1, 32'd1, 0);
    drive_sample(1, 32'hFFFF_FFFF, 1);
    expect_result(1, -1, 1, 2, 1);

    // MODE1 min with back-pressure: the result must stay held and block input
    out_ready[1] = 1'b0;
    drive_sample(1, 32'sd984, 0);
    drive_sample(1, 32'sd34, 0);
    drive_sample(1, 32'sd2398, 0);
    drive_sample(1, 32'sd24, 1);
    expect_result(1, 24, 3, 4, 0);
    in_valid[1] = 1'b1; in_data[1] = 32'sd5; in_last[1] = 1'b1;
    repeat (5) begin
      @(negedge clk); #1;
      chk("hold valid", out_valid[1], 1);
      chk("hold value", oval[1], 24);
      chk("hold in_ready", in_ready[1], 0);
    end
    @(posedge clk); #1;
    out_ready[1] = 1'b1;
    @(negedge clk); #1;
    chk("release same-cycle in_ready", in_ready[1], 0);
    @(posedge clk); #1;
    @(negedge clk); #1;
    chk("release next-cycle in_ready", in_ready[1], 1);
    chk("release next-cycle out_valid", out_valid[1], 0);
    @(posedge clk); #1;
    in_valid[1] = 1'b0; in_last[1] = 1'b0;
    expect_result(1, 5, 0, 1, 0);

    // MAX_LEN=4 auto-close: six samples with in_last only on the sixth
    thresh[0] = 32'd0;
    drive_sample(0, 32'sd10, 0);
    drive_sample(0, 32'sd20, 0);
    drive_sample(0, 32'sd5, 0);
    drive_sample(0, 32'sd7, 0);
    expect_result(0, 20, 1, 4, 1);
    thresh[0] = 32'sd4;
    drive_sample(0, 32'sd3, 0);
    drive_sample(0, -32'sd2, 1);
    expect_result(0, 3, 0, 2, 0);

    // clear mid-frame; the sample presented together with clear is dropped
    thresh[0] = 32'd0;
    drive_sample(0, 32'sd100, 0);
    drive_sample(0, 32'sd200, 0);
    clr[0] = 1'b1; in_valid[0] = 1'b1; in_data[0] = 32'sd999; in_last[0] = 1'b1;
    @(negedge clk); #1;
    chk("clear in_ready", in_ready[0], 0);
    @(posedge clk); #1;
    clr[0] = 1'b0; in_valid[0] = 1'b0; in_last[0] = 1'b0;
    thresh[0] = -32'sd6;
    drive_sample(0, -32'sd5, 0);
    drive_sample(0, -32'sd7, 1);
    expect_result(0, -5, 0, 2, 1);

    // clear in HOLD wins over a simultaneous out_ready
    out_ready[1] = 1'b0;
    drive_sample(1, 32'sd1, 0);
    drive_sample(1, 32'sd2, 1);
    expect_result(1, 1, 0, 2, 0);
    clr[1] = 1'b1; out_ready[1] = 1'b1;
    @(posedge clk); #1;
    clr[1] = 1'b0;
    @(negedge clk); #1;
    chk("clear hold out_valid", out_valid[1], 0);
    chk("clear hold in_ready", in_ready[1], 1);
    @(posedge clk); #1;

    // reset pulse in HOLD discards the pending result
    out_ready[1] = 1'b0;
    drive_sample(1, -32'sd3, 0);
    drive_sample(1, -32'sd8, 1);
    expect_result(1, -8, 1, 2, 1);
    rst_n = 1'b0;
    @(negedge clk); #1;
    chk("reset hold out_valid", out_valid[1], 0);
    chk("reset hold in_ready", in_ready[1], 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready[1] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    drive_sample(1, 32'sd7, 0);
    drive_sample(1, 32'sd6, 0);
    drive_sample(1, 32'sd9, 1);
    expect_result(1, 6, 1, 3, 0);

    repeat (3) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
